// File: rtl/shift_left_iterative.sv
// rtl/shift_left_iterative.sv - multi-cycle logical left shifter, one bit per clock
// Valid/ready on both sides; a single operation in flight at a time.
module shift_left_iterative #(
  parameter int N = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         in,
  input  logic [$clog2(N)-1:0] shamt,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N-1:0]         out,
  output logic                 busy
);

  localparam int SW = $clog2(N);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    data_q, data_d;
  logic [SW-1:0]   count_q, count_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic            busy_q, busy_d;
  logic [N-1:0]    out_q, out_d;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    count_d = count_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          data_d  = in;
          count_d = shamt;
          state_d = (shamt == '0) ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        data_d  = {data_q[N-2:0], 1'b0};
        count_d = count_q - SW'(1);
        if (count_q == SW'(1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so they depend on state only.
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
    busy_d      = (state_d == S_SHIFT) || (state_d == S_DONE);
    out_d       = (state_d == S_DONE) ? data_d : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      data_q      <= '0;
      count_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      out_q       <= '0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      out_q       <= out_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out       = out_q;

endmodule

// File: tb/tb_shift_left_iterative.sv
// tb/tb_shift_left_iterative.sv - directed and randomised checks for shift_left_iterative
module tb_shift_left_iterative;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] din;
  logic [4:0]  shamt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] dout;
  logic        busy;

  int total = 0;
  int passed = 0;

  shift_left_iterative #(.N(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in        (din),
    .shamt     (shamt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (dout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, observed=timeout expected=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic run_op(input logic [31:0] a, input logic [4:0] s, input int gap,
                        input int stall, input bit early, input bit noisy);
    logic [31:0] exp;
    int lat;
    exp = a << s;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (gap) @(negedge clk);
    in_valid  = 1'b1;
    din       = a;
    shamt     = s;
    out_ready = early;
    chk("accept_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = noisy;
    din      = $urandom;
    shamt    = 5'($urandom_range(0, 31));
    while (!out_valid && lat <= 40) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'(s) + 32'd1);
    chk("result", dout, exp);
    chk("done_in_ready", {31'd0, in_ready}, 32'd0);
    chk("done_busy", {31'd0, busy}, 32'd1);
    if (!early) begin
      repeat (stall) begin
        @(negedge clk);
        chk("stall_out", dout, exp);
        chk("stall_valid", {31'd0, out_valid}, 32'd1);
        chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("post_in_ready", {31'd0, in_ready}, 32'd1);
    chk("post_valid", {31'd0, out_valid}, 32'd0);
    chk("post_out_zero", dout, 32'd0);
    chk("post_busy", {31'd0, busy}, 32'd0);
    if (noisy) begin
      // The input held during the handshake edge must not have been taken.
      @(negedge clk);
      chk("no_overlap_accept", {31'd0, in_ready}, 32'd1);
    end
  endtask

  initial begin
    bit seen_valid;
    rst       = 1'b1;
    in_valid  = 1'b1;
    din       = 32'hFFFF_FFFF;
    shamt     = 5'd3;
    out_ready = 1'b0;

    // Reset held for two cycles with a pending operand
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out", dout, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rst_nothing_accepted", {31'd0, busy}, 32'd0);

    // shamt=0 pass-through
    run_op(32'h1234_5678, 5'd0, 0, 0, 1'b1, 1'b0);
    // Mid and max shifts
    run_op(32'h0000_00F1, 5'd4, 1, 0, 1'b0, 1'b0);
    run_op(32'h8000_0001, 5'd31, 0, 2, 1'b0, 1'b0);
    run_op(32'h0000_0000, 5'd17, 0, 0, 1'b1, 1'b0);
    run_op(32'hFFFF_FFFF, 5'd1, 2, 1, 1'b0, 1'b0);
    // Backpressure with new data offered throughout
    run_op(32'hA5A5_A5A5, 5'd8, 0, 10, 1'b0, 1'b1);

    // Reset mid-shift
    in_valid = 1'b1;
    din      = 32'h0000_0001;
    shamt    = 5'd20;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    seen_valid = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid) seen_valid = 1'b1;
    end
    chk("midrst_no_output", {31'd0, seen_valid}, 32'd0);

    // Randomised back-to-back operations
    for (int i = 0; i < 1000; i++) begin
      run_op($urandom, 5'($urandom_range(0, 31)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
